// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle shift-add multiplier with signed/saturate modes
module seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               sat_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product_full,
  output logic [WIDTH-1:0]   product,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_r;
  logic               signed_r;
  logic               sat_r;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_in;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] fin_full;
  logic               fin_of;
  logic [WIDTH-1:0]   fin_prod;

  // Operand magnitudes and result sign; the most negative value maps to 2^(WIDTH-1) unchanged as unsigned
  always_comb begin
    mag_a  = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b  = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
    neg_in = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]) && (|a) && (|b);
  end

  // One shift-add step: the multiplier sits in the low half and is consumed LSB first
  always_comb begin
    addend   = acc[0] ? mcand : '0;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  // Final sign fix-up, overflow detection and saturation, applied on the last step
  always_comb begin
    fin_full = neg_r ? (~acc_next + 1'b1) : acc_next;
    if (signed_r) begin
      fin_of = !((&fin_full[2*WIDTH-1:WIDTH-1]) || !(|fin_full[2*WIDTH-1:WIDTH-1]));
    end else begin
      fin_of = |fin_full[2*WIDTH-1:WIDTH];
    end
    fin_prod = fin_full[WIDTH-1:0];
    if (sat_r && fin_of) begin
      if (!signed_r) begin
        fin_prod = '1;
      end else if (fin_full[2*WIDTH-1]) begin
        fin_prod = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        fin_prod = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  // Control FSM and datapath registers; outputs only change on the CALC-to-DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      product_full <= '0;
      product      <= '0;
      overflow     <= 1'b0;
      mcand        <= '0;
      acc          <= '0;
      cnt          <= '0;
      neg_r        <= 1'b0;
      signed_r     <= 1'b0;
      sat_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= mag_a;
            acc      <= {{WIDTH{1'b0}}, mag_b};
            cnt      <= '0;
            neg_r    <= neg_in;
            signed_r <= signed_mode;
            sat_r    <= sat_mode;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            product_full <= fin_full;
            product      <= fin_prod;
            overflow     <= fin_of;
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
